spi_master_arb: RTL and testbench
=================================

// Module: spi_master_arb
// PURPOSE
//  Round-robin arbiter plus SPI master engine sharing one SPI bus (sck/mosi/miso)
//  among NREQ on-chip requesters, each owning its own slave select. Sequences full
//  frames for spi_rx-style slaves: data bits LSB first, then TAIL_CLKS trailing sck
//  edges so the slave can latch data and return to idle. Sits between host logic and pads.
// PARAMETERS
//  NREQ         2  number of requesters / slave selects (2..8)
//  DATA_LENGTH  8  bits per frame
//  TAIL_CLKS    4  extra sck rising edges after data, mosi=0 during tail
//  CLK_DIV      2  clk cycles per sck half period (>=1)
// PORTS
//  clk      in   1                 system clock, all logic on posedge
//  prst     in   1                 asynchronous reset, active high
//  req      in   NREQ              per-requester transfer request (level)
//  lock     in   NREQ              per-requester bus lock (SPI_ARB_LOCK_EN only)
//  tx_data  in   NREQ*DATA_LENGTH  requester i data at [i*DATA_LENGTH +: DATA_LENGTH]
//  gnt      out  NREQ              1-cycle pulse: tx_data[i] latched, frame started
//  done     out  NREQ              1-cycle pulse: frame for i complete, rx_data valid
//  rx_data  out  DATA_LENGTH       last received frame, held until next done
//  busy     out  1                 high from gnt cycle until back in IDLE
//  sck      out  1                 SPI clock, CPOL=0, idle low
//  mosi     out  1                 master out, changes only while sck low
//  miso     in   1                 master in, sampled on sck rising edge
//  ss       out  NREQ              active-low selects, at most one low at any time
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, done=0, rx_data=0, busy=0, sck=0, mosi=0, ss all 1,
//   RR pointer=0, state=IDLE. Reset mid-frame aborts; no done pulse for aborted frame.
//  States: IDLE -> SETUP -> XFER -> TAIL -> GAP -> IDLE.
//  IDLE: if any req, pick first set bit searching from pointer upward, wrapping. Next
//   cycle: gnt[i]=1, ss[i]=0, busy=1, shift reg<=tx_data[i], mosi=bit0; pointer<=(i+1)%NREQ.
//  SETUP: CLK_DIV cycles with sck low, then XFER.
//  XFER: sck high CLK_DIV cycles, low CLK_DIV cycles per bit; on each rising edge
//   sample miso into rx shift bit k (LSB first); on falling edge shift mosi to bit k+1.
//   After DATA_LENGTH rising edges -> TAIL.
//  TAIL: TAIL_CLKS further sck pulses, same timing, mosi=0, miso ignored.
//  End of last tail low phase: ss[i]=1, done[i]=1, rx_data<=rx shift, -> GAP.
//  ss low time = CLK_DIV*(1+2*(DATA_LENGTH+TAIL_CLKS)) clk cycles exactly.
//  GAP: CLK_DIV cycles all ss high, sck low; busy drops entering IDLE.
//  req changes during a frame do not affect it; req held high after done is
//   re-arbitrated in IDLE (RR fairness: other pending requesters served first).
//  req deasserted before grant: no transfer. Counters sized $clog2 of their max+1.
//  Simultaneous req from all: order 0,1,..,NREQ-1 from reset, then continues rotating.
// CONFIGURATION
//  SPI_ARB_LOCK_EN defined: if lock[i] && req[i] at done cycle, skip GAP and IDLE:
//   ss[i] stays low, next cycle gnt[i] pulses, new tx_data latched, enter SETUP;
//   pointer not advanced. lock dropped -> normal GAP and arbitration.
//  Not defined: lock port present but ignored; every frame ends with GAP.
// TESTING (NREQ=2, DATA_LENGTH=8, TAIL_CLKS=4, CLK_DIV=2)
//  Reset mid-frame -> ss=2'b11, sck=0, mosi=0 same cycle; no done; next req served from 0.
//  req=01, tx_data[0]=8'hA5, miso drives 8'h3C LSB first -> gnt[0] 1 cycle, mosi 1,0,1,0,
//   0,1,0,1 then 0x4, 12 sck pulses, ss[0] low 50 cycles, done[0] with rx_data=8'h3C.
//  req=11 held -> frames granted 0,1,0,1; ss never both low; >=2 cycles ss high between.
//  req[1] pulses 1 cycle while frame for 0 runs -> ignored unless still high at IDLE.
//  With SPI_ARB_LOCK_EN, lock=01 req=11 -> two back-to-back frames to 0, ss[0] low
//   continuously, then lock=0 -> requester 1 granted next.
//  Without SPI_ARB_LOCK_EN same stimulus -> alternating 0,1 grants, lock ignored.

Source files
------------

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbiter and SPI master (CPOL=0) sharing one
// sck/mosi/miso bus among NREQ requesters, each with its own active-low select.
// Each frame sends DATA_LENGTH bits LSB first, then TAIL_CLKS trailing sck pulses.
// Optional feature macro: SPI_ARB_LOCK_EN (locked requester keeps the bus between frames).
module spi_master_arb #(
    parameter int NREQ        = 2,
    parameter int DATA_LENGTH = 8,
    parameter int TAIL_CLKS   = 4,
    parameter int CLK_DIV     = 2
) (
    input  logic                        clk,
    input  logic                        prst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             lock,
    input  logic [NREQ*DATA_LENGTH-1:0] tx_data,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic [DATA_LENGTH-1:0]      rx_data,
    output logic                        busy,
    output logic                        sck,
    output logic                        mosi,
    input  logic                        miso,
    output logic [NREQ-1:0]             ss
);

    localparam int NPULSE = DATA_LENGTH + TAIL_CLKS;
    localparam int CW     = $clog2(NPULSE + 1);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW     = $clog2(NREQ);

    // RELOAD is the done cycle of a locked frame, only reachable with the lock feature
    typedef enum logic [2:0] {IDLE, SETUP, XFER, TAIL, GAP, RELOAD} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          div_q, div_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] sh_q, sh_d;
    logic [DATA_LENGTH-1:0] rxs_q, rxs_d;
    logic [DATA_LENGTH-1:0] rx_q, rx_d;
    logic [IW-1:0]          cur_q, cur_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic [NREQ-1:0]        ss_q, ss_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [NREQ-1:0]        done_q, done_d;

    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] sel_next;
    logic          load;
    logic [IW-1:0] load_idx;
    logic          div_end;
    logic          relock;

`ifdef SPI_ARB_LOCK_EN
    assign relock = lock[cur_q] & req[cur_q];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign relock      = 1'b0;
`endif

    assign div_end = (div_q == DW'(CLK_DIV - 1));

    // Round-robin pick: first pending request at or above the pointer, wrapping
    always_comb begin
        int unsigned idx;
        found    = 1'b0;
        sel      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
        sel_next = (32'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
    end

    // Frame sequencer: next-state and registered-output values
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        rxs_d    = rxs_q;
        rx_d     = rx_q;
        cur_d    = cur_q;
        ptr_d    = ptr_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        ss_d     = ss_q;
        gnt_d    = '0;
        done_d   = '0;
        load     = 1'b0;
        load_idx = cur_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    load     = 1'b1;
                    load_idx = sel;
                    ptr_d    = sel_next;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    rxs_d   = {miso, rxs_q[DATA_LENGTH-1:1]};
                    state_d = XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            XFER: begin
                if (div_end) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_LENGTH - 1)) begin
                            mosi_d  = 1'b0;
                            state_d = TAIL;
                        end else begin
                            sh_d   = sh_q >> 1;
                            mosi_d = sh_d[0];
                        end
                    end else begin
                        sck_d = 1'b1;
                        rxs_d = {miso, rxs_q[DATA_LENGTH-1:1]};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TAIL: begin
                if (div_end) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        cnt_d = cnt_q + 1'b1;
                    end else if (cnt_q == CW'(NPULSE)) begin
                        done_d[cur_q] = 1'b1;
                        rx_d          = rxs_q;
                        cnt_d         = '0;
                        if (relock) begin
                            state_d = RELOAD;
                        end else begin
                            ss_d    = '1;
                            state_d = GAP;
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_end) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RELOAD: begin
                load = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Grant and locked re-grant share the frame-start load
        if (load) begin
            gnt_d[load_idx] = 1'b1;
            ss_d            = '1;
            ss_d[load_idx]  = 1'b0;
            busy_d          = 1'b1;
            sh_d            = tx_data[load_idx*DATA_LENGTH +: DATA_LENGTH];
            mosi_d          = sh_d[0];
            cur_d           = load_idx;
            cnt_d           = '0;
            div_d           = '0;
            state_d         = SETUP;
        end
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            rxs_q   <= '0;
            rx_q    <= '0;
            cur_q   <= '0;
            ptr_q   <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            ss_q    <= '1;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rxs_q   <= rxs_d;
            rx_q    <= rx_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            ss_q    <= ss_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign busy    = busy_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: scoreboard bench for spi_master_arb (NREQ=2, 8 data bits,
// 4 tail clocks, CLK_DIV=2). Stimulus pushes expected frames; a monitor checks
// each grant and completed frame. Honours SPI_ARB_LOCK_EN when defined.
module tb_spi_master_arb;

    typedef struct {
        int       idx;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic        clk = 1'b0;
    logic        prst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  lock = '0;
    logic [15:0] tx_data = '0;
    logic [1:0]  gnt, done, ss;
    logic [7:0]  rx_data;
    logic        busy, sck, mosi;
    logic        miso = 1'b0;

    int tests = 0;
    int fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    spi_master_arb #(.NREQ(2), .DATA_LENGTH(8), .TAIL_CLKS(4), .CLK_DIV(2)) dut (
        .clk(clk), .prst(prst), .req(req), .lock(lock), .tx_data(tx_data),
        .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy),
        .sck(sck), .mosi(mosi), .miso(miso), .ss(ss)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state
    bit         active = 0;
    exp_t       cur;
    int         cidx = 0;
    int         pcnt = 0, sslow = 0, hi_cnt = 100, gnt_seen = 0, done_seen = 0;
    logic [7:0] mos = '0;
    logic [7:0] word = '0;
    logic       tail_bad = 1'b0;
    logic       sck_prev = 1'b0;

    // Monitor: pops the scoreboard on done, checks grants, models the slave miso
    always @(negedge clk) begin
        if (prst) begin
            active   = 0;
            sck_prev = 1'b0;
            hi_cnt   = 100;
            miso     = 1'b0;
        end else begin
            if (done !== 2'b00) begin
                done_seen++;
                if (!active || q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    cur = q.pop_front();
                    chk("done_idx", 32'(done), 32'd1 << cur.idx);
                    chk("rx_data", 32'(rx_data), 32'(cur.rx));
                    chk("mosi_bits", 32'(mos), 32'(cur.tx));
                    chk("sck_pulses", pcnt, 12);
                    chk("ss_low_cycles", sslow, 50);
                    chk("tail_mosi_zero", 32'(tail_bad), 0);
`ifndef SPI_ARB_LOCK_EN
                    chk("ss_high_at_done", 32'(ss), 32'd3);
`endif
                end
                active = 0;
            end
            if (gnt !== 2'b00) begin
                gnt_seen++;
                if (q.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 0);
                end else begin
                    chk("gnt_idx", 32'(gnt), 32'd1 << q[0].idx);
                    chk("busy_at_gnt", 32'(busy), 1);
                    chk("one_ss_low", 32'(ss), (~(32'd1 << q[0].idx)) & 32'd3);
`ifndef SPI_ARB_LOCK_EN
                    if (done_seen > 0) chk("gap_ge2", 32'(hi_cnt >= 2), 1);
`endif
                    active   = 1;
                    cidx     = q[0].idx;
                    pcnt     = 0;
                    sslow    = 0;
                    mos      = '0;
                    tail_bad = 1'b0;
                    word     = q[0].rx;
                    miso     = word[0];
                end
            end
            hi_cnt = (ss == 2'b11) ? hi_cnt + 1 : 0;
            if (active) begin
                if (ss[cidx] == 1'b0) sslow++;
                if (sck && !sck_prev) begin
                    if (pcnt < 8) mos[pcnt] = mosi;
                    else if (mosi) tail_bad = 1'b1;
                    pcnt++;
                end
                if (!sck && sck_prev) miso = (pcnt < 8) ? word[pcnt] : 1'b0;
            end
            sck_prev = sck;
        end
    end

    task automatic wait_gnts(input int n, input int budget);
        int c = 0;
        while (gnt_seen < n && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk("wait_gnt", 32'(gnt_seen >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((q.size() != 0 || busy) && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk("wait_idle", 32'(q.size() == 0 && !busy), 1);
    endtask

    task automatic do_reset();
        q.delete();
        @(posedge clk); #3;
        prst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        prst = 1'b0;
    endtask

    initial begin
        int b;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", 32'(ss), 3);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rx", 32'(rx_data), 0);
        @(negedge clk);
        prst = 1'b0;

        // Single frame: A5 out, 3C in
        tx_data = {8'h00, 8'hA5};
        q.push_back('{0, 8'hA5, 8'h3C});
        req = 2'b01;
        wait_gnts(1, 20);
        req = 2'b00;
        wait_idle(200);

        // Reset mid-frame aborts; pointer returns to 0
        b = gnt_seen;
        q.push_back('{0, 8'hA5, 8'h3C});
        req = 2'b01;
        wait_gnts(b + 1, 20);
        req = 2'b00;
        repeat (20) @(posedge clk);
        #3;
        q.delete();
        prst = 1'b1;
        #1;
        chk("midrst_ss", 32'(ss), 3);
        chk("midrst_sck", 32'(sck), 0);
        chk("midrst_mosi", 32'(mosi), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rx", 32'(rx_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        prst = 1'b0;

        // Both requesting: 0,1,0,1
        b = gnt_seen;
        tx_data = {8'h81, 8'h5C};
        q.push_back('{0, 8'h5C, 8'hE1});
        q.push_back('{1, 8'h81, 8'h42});
        q.push_back('{0, 8'h5C, 8'h0F});
        q.push_back('{1, 8'h81, 8'hF0});
        req = 2'b11;
        wait_gnts(b + 4, 1000);
        req = 2'b00;
        wait_idle(200);

        // Short req[1] pulse during frame 0 is ignored
        b = gnt_seen;
        q.push_back('{0, 8'h5C, 8'hE7});
        req = 2'b01;
        wait_gnts(b + 1, 20);
        repeat (5) @(posedge clk);
        #2 req = 2'b11;
        @(posedge clk);
        #2 req = 2'b00;
        wait_idle(200);
        b = gnt_seen;
        repeat (30) @(posedge clk);
        chk("no_extra_gnt", gnt_seen, b);
        chk("idle_busy", 32'(busy), 0);

        // Lock stimulus: lock=01, req=11
        do_reset();
        b = gnt_seen;
        tx_data = {8'h3E, 8'h11};
`ifdef SPI_ARB_LOCK_EN
        q.push_back('{0, 8'h11, 8'h99});
        q.push_back('{0, 8'h22, 8'h6B});
        q.push_back('{1, 8'h3E, 8'hD4});
        lock = 2'b01;
        req  = 2'b11;
        wait_gnts(b + 1, 20);
        tx_data[7:0] = 8'h22;
        wait_gnts(b + 2, 200);
        lock = 2'b00;
        wait_gnts(b + 3, 200);
        req = 2'b00;
`else
        q.push_back('{0, 8'h11, 8'h99});
        q.push_back('{1, 8'h3E, 8'hD4});
        lock = 2'b01;
        req  = 2'b11;
        wait_gnts(b + 1, 20);
        tx_data[7:0] = 8'h22;
        wait_gnts(b + 2, 200);
        req  = 2'b00;
        lock = 2'b00;
`endif
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
